// File: rtl/modn_run_controller.sv
// Run sequencer for the programmable mod-N counter datapath.
// Steps the counter through a commanded number of full wraps.
module modn_run_controller #(
  parameter int LENGTH = 3,
  parameter int REPW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LENGTH-1:0] cmd_mod,
  input  logic [REPW-1:0]   cmd_reps,
  input  logic              en,
  input  logic              abort,
  output logic [LENGTH-1:0] dataout,
  output logic [REPW-1:0]   reps_left,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [LENGTH-1:0] cnt_q;
  logic [LENGTH-1:0] tc_q;
  logic [REPW-1:0]   reps_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic at_tc;
  logic last_rep;
  logic accept;

  assign at_tc    = (cnt_q == tc_q);
  assign last_rep = (reps_q == REPW'(1));
  assign accept   = cmd_valid && ready_q;

  assign wrap = (state_q == S_RUN) && en
              && !abort && at_tc;

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dataout   = cnt_q;
  assign reps_left = reps_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tc_q    <= '0;
      reps_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            tc_q    <= cmd_mod;
            reps_q  <= cmd_reps;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (cmd_reps != '0) begin
              state_q <= S_RUN;
            end else begin
              // empty run goes straight to the done strobe
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            reps_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (en) begin
            if (!at_tc) begin
              cnt_q <= cnt_q + LENGTH'(1);
            end else begin
              cnt_q  <= '0;
              reps_q <= reps_q - REPW'(1);
              if (last_rep) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          reps_q  <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/modn_run_controller.md
# modn_run_controller

Sequencer for the team's programmable mod-N counter datapath. It accepts a run command over a valid/ready handshake that specifies a modulus and a repetition count. It then steps the counter through that many full wrap cycles, gated by an enable, and signals each terminal count and the end of the run. Commands come from upstream control logic; `dataout`, `wrap` and `done` feed downstream timing logic.

## Interface
- `LENGTH`, 3: count width; largest modulus is 2^LENGTH (default 8).
- `REPW`, 4: width of the repetition count.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_mod`  in  LENGTH  terminal count; modulus = cmd_mod+1.
- `cmd_reps`  in  REPW  number of full wraps to run; 0 = empty run.
- `en`  in  1  count enable; low pauses the count in RUN.
- `abort`  in  1  cancel the current run.
- `dataout`  out  LENGTH  current count value.
- `reps_left`  out  REPW  wraps remaining in the current run.
- `busy`  out  1  state is not IDLE.
- `wrap`  out  1  terminal-count strobe (combinational).
- `done`  out  1  one-cycle run-complete strobe.

## Operation
- States are IDLE, RUN and DONE. Encoding is free.
- Reset (reset=0), applied at any time, takes effect immediately without waiting for a clock edge:
  - state=IDLE, `dataout`=0, `reps_left`=0, latched terminal count tc=0.
  - Outputs: `cmd_ready`=1, `busy`=0, `wrap`=0, `done`=0.
  - Any run in progress is lost and no `done` is produced.
- IDLE:
  - `cmd_ready`=1. `en` and `abort` are ignored.
  - A command is accepted on an edge where cmd_valid && cmd_ready. On acceptance: tc<=cmd_mod, `reps_left`<=cmd_reps, `dataout`<=0.
  - Next state is RUN when cmd_reps≠0, DONE when cmd_reps=0.
- RUN:
  - `cmd_ready`=0; `cmd_valid` is ignored.
  - If abort=1: next state IDLE, `dataout`<=0, `reps_left`<=0, no `wrap`, no `done`. `abort` has priority over every other event.
  - Else if en=0: `dataout` and `reps_left` hold.
  - Else if dataout≠tc: `dataout`<=dataout+1.
  - Else (the terminal case): `dataout`<=0 and `reps_left`<=reps_left−1. If reps_left=1, next state is DONE.
- `wrap` = (state==RUN) && en && !abort && (dataout==tc).
- DONE:
  - `done`=1 for exactly one cycle, `dataout`=0, `cmd_ready`=0.
  - Next state is always IDLE. `abort` in DONE is a don't-care; `done` still pulses.
- Arithmetic:
  - `dataout` never exceeds tc and never wraps through 2^LENGTH except when tc=2^LENGTH−1, where tc+1 wraps to 0 naturally.
  - `reps_left` never underflows.
- tc=0 (modulus 1): `dataout` stays 0 and `wrap` asserts on every enabled RUN cycle.

## Timing
- Command handshake completes on edge k. From cycle k+1: state=RUN, `dataout`=0, `busy`=1.
- Latency to `done`, counted in enabled cycles:
  - With continuous en=1, the run lasts reps×(tc+1) cycles in RUN, then one DONE cycle, then IDLE.
  - The next command can be accepted at the first edge after state returns to IDLE, i.e. one cycle after the DONE cycle.
- `wrap` and `done` never assert in the same cycle.
- `wrap` asserts in the cycle `dataout` shows tc; `dataout` reads 0 in the following cycle.
- An empty run (cmd_reps=0) gives DONE in cycle k+1 and IDLE in cycle k+2, with no RUN cycles and no `wrap`.
- `cmd_mod` and `cmd_reps` are sampled only at acceptance. Later changes have no effect on a run in progress.

## Test plan
- Reset mid-count: command mod 8 (cmd_mod=7), reps 3; drive reset low while dataout=5 -> immediately dataout=0, busy=0, cmd_ready=1; no done follows.
- Basic run: cmd_mod=7, reps=2, en=1, accepted at edge k -> dataout counts 0..7 in cycles k+1..k+8 and again in k+9..k+16; wrap in cycles k+8 and k+16; done=1 in k+17; cmd_ready=1 in k+18.
- Enable gating: cmd_mod=4, reps=1; deassert en for 3 cycles while dataout=2 -> dataout holds at 2, no wrap; the run completes 3 cycles later than the ungated run; a single wrap occurs at dataout=4.
- Boundaries:
  - cmd_mod=0, reps=3 -> wrap high for 3 consecutive cycles with dataout=0, then done.
  - cmd_reps=0 -> done at k+1, never wrap, never RUN.
- Abort:
  - abort=1 in RUN while dataout=7=tc and en=1 -> no wrap; IDLE next cycle, dataout=0, reps_left=0, no done.
  - A new command is accepted on the following edge.
- Back-to-back commands: hold cmd_valid=1 with a second command (cmd_mod=2, reps=1) during a run -> cmd_ready stays 0 until IDLE; the second command is accepted one cycle after the DONE cycle and counts 0,1,2.
